// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the handshaked sequential ALU (alu_seq).
//   alu_op_t   : 3-bit operation encoding carried on ALUControl
//   FLAG_*     : bit positions inside the 4-bit {N,Z,C,V} flag vector
//   state_t    : control FSM states
//   pack_flags : builds a flag vector from its four components
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
// Unsigned iterative multiplier, one multiplier bit per clock, 2N-bit
// accumulator.
//   clk, rst_n : clock, asynchronous active-low reset (aborts any operation)
//   start      : load a/b; bit 0 of b is consumed on this same edge
//   a, b       : N-bit unsigned operands, sampled only when start is high
//   busy       : high while bits 1..N-1 are still being accumulated
//   done       : one-cycle pulse, product is final while it is high
//   product    : 2N-bit accumulator; holds the last result until next start
// Timing: start on edge 0, remaining bits on edges 1..N-1, done is high in
// the cycle after edge N-1, so a consumer registering on done sees the
// result N edges after start.
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;   // multiplicand, pre-shifted to the current bit weight
  logic [N-1:0]   mplier;  // remaining multiplier bits, current bit at [0]
  logic [CW-1:0]  cnt;     // index of the multiplier bit handled next

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= b[0] ? {{N{1'b0}}, a} : '0;
        mcand  <= {{(N-1){1'b0}}, a, 1'b0};
        mplier <= b >> 1;
        cnt    <= CW'(1);
        busy   <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (cnt == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Handshaked ALU with registered result and {N,Z,C,V} flags. Single-cycle
// ops finish one cycle after accept; MUL runs on shift_add_multiplier and
// finishes N cycles after accept.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake, in_ready == (state == IDLE)
//   A, B, ALUControl      : operands and alu_op_t operation
//   out_valid / out_ready : result handshake, result held until taken
//   ALUResult, ALUFlags   : registered result and {N,Z,C,V}
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] ALUResult,
  output logic [3:0]   ALUFlags
);

  state_t state, next_state;

  alu_op_t op;
  logic    accept;
  logic    is_mul;

  logic           mul_busy;
  logic           mul_done;
  logic [2*N-1:0] mul_product;

  logic [SW-1:0] sh;
  logic [N:0]    sum;
  logic [N:0]    diff;
  logic [N:0]    sll_w;   // {last bit shifted out, shifted value}
  logic [N:0]    srl_w;   // {shifted value, last bit shifted out}
  logic [N-1:0]  dp_res;
  logic          dp_c;
  logic          dp_v;
  logic [3:0]    dp_flags;
  logic [N-1:0]  mul_res;
  logic [3:0]    mul_flags;

  logic [N-1:0]  result_q;
  logic [3:0]    flags_q;

  assign op     = alu_op_t'(ALUControl);
  assign accept = in_valid && in_ready;
  assign is_mul = (op == OP_MUL);

  shift_add_multiplier #(.N(N)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul && !mul_busy),
    .a       (A),
    .b       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath works straight off the inputs so its result can be
  // registered on the accept edge itself.
  assign sh    = B[SW-1:0];
  assign sum   = {1'b0, A} + {1'b0, B};
  assign diff  = {1'b0, A} - {1'b0, B};   // diff[N] is the borrow
  assign sll_w = {1'b0, A} << sh;         // top bit = A[N-sh], 0 when sh == 0
  assign srl_w = {A, 1'b0} >> sh;         // low bit = A[sh-1], 0 when sh == 0

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a value unassigned and infers a latch.
  always_comb begin
    dp_res = '0;
    dp_c   = 1'b0;
    dp_v   = 1'b0;
    case (op)
      OP_ADD: begin
        dp_res = sum[N-1:0];
        dp_c   = sum[N];
        dp_v   = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
      end
      OP_SUB: begin
        dp_res = diff[N-1:0];
        dp_c   = diff[N];
        dp_v   = (A[N-1] != B[N-1]) && (diff[N-1] != A[N-1]);
      end
      OP_AND: dp_res = A & B;
      OP_OR:  dp_res = A | B;
      OP_XOR: dp_res = A ^ B;
      OP_SLL: begin
        dp_res = sll_w[N-1:0];
        dp_c   = sll_w[N];
      end
      OP_SRL: begin
        dp_res = srl_w[N:1];
        dp_c   = srl_w[0];
      end
      OP_MUL: ;  // produced by the multiplier
      default: ;
    endcase
  end

  assign dp_flags  = pack_flags(dp_res[N-1], dp_res == '0, dp_c, dp_v);
  assign mul_res   = mul_product[N-1:0];
  assign mul_flags = pack_flags(mul_res[N-1], mul_res == '0,
                                |mul_product[2*N-1:N], 1'b0);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)    next_state = is_mul ? BUSY : DONE;
      BUSY:    if (mul_done)  next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: the result/flag registers are reset as well, so the outputs are
  // zero (never X) from reset until the first op completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (state == IDLE && accept && !is_mul) begin
      result_q <= dp_res;
      flags_q  <= dp_flags;
    end else if (state == BUSY && mul_done) begin
      result_q <= mul_res;
      flags_q  <= mul_flags;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign ALUResult = result_q;
  assign ALUFlags  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed self-checking bench for alu_seq (N = 32). Inputs are driven 1 ns
// after the rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND = 3'b010,
                         XOR = 3'b100, SLL = 3'b101, SRL = 3'b110,
                         MUL = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic [2:0]  ALUControl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic [3:0]  ALUFlags;

  int checks = 0;
  int errors = 0;

  alu_seq #(.N(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .ALUFlags   (ALUFlags)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one op for a single accept edge, then scramble the operands to
  // show they were captured.
  task automatic send(input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    in_valid   = 1'b1;
    ALUControl = op;
    A          = a;
    B          = b;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    A          = 32'hA5A5_5A5A;
    B          = 32'h0F0F_F0F0;
    ALUControl = ADD;
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " in_ready after take"}, 64'(in_ready), 64'd1);
    check({tag, " out_valid after take"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_single(input string tag, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic [3:0] exp_flags);
    send(op, a, b);
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check({tag, " result"}, 64'(ALUResult), 64'(exp_res));
    check({tag, " flags"}, 64'(ALUFlags), 64'(exp_flags));
    take_result(tag);
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic [3:0] exp_flags);
    int lat;
    send(MUL, a, b);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd32);
    check({tag, " result"}, 64'(ALUResult), 64'(exp_res));
    check({tag, " flags"}, 64'(ALUFlags), 64'(exp_flags));
    take_result(tag);
  endtask

  initial begin
    int seen;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    A          = '0;
    B          = '0;
    ALUControl = ADD;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", 64'(ALUResult), 64'd0);
    check("reset flags", 64'(ALUFlags), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Flags are {N,Z,C,V}
    run_single("add wrap",  ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
    run_single("add ovf",   ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
    run_single("sub 3-5",   SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b1010);
    run_single("sll sh1",   SLL, 32'h8000_0001, 32'h0000_0021, 32'h0000_0002, 4'b0010);
    run_single("srl sh0",   SRL, 32'h1234_5679, 32'h0000_0040, 32'h1234_5679, 4'b0000);
    run_single("srl sh4",   SRL, 32'h0000_001F, 32'h0000_0004, 32'h0000_0001, 4'b0010);
    run_single("and",       AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000);
    run_single("xor zero",  XOR, 32'h1357_9BDF, 32'h1357_9BDF, 32'h0000_0000, 4'b0100);

    run_mul("mul 2^16*2^16", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b0110);
    run_mul("mul 7*6",       32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 4'b0000);

    // Backpressure: result held while out_ready is low, new in_valid ignored
    send(ADD, 32'h0000_0001, 32'h0000_0002);
    in_valid   = 1'b1;
    ALUControl = SUB;
    A          = 32'h0000_0009;
    B          = 32'h0000_0004;
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp in_ready", 64'(in_ready), 64'd0);
      check("bp result", 64'(ALUResult), 64'd3);
      check("bp flags", 64'(ALUFlags), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    take_result("bp");
    @(posedge clk); #1;
    check("bp no stray op", 64'(out_valid), 64'd0);

    // Reset in the middle of a MUL: outputs cleared, nothing completes later
    send(MUL, 32'h0000_0007, 32'h0000_0006);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid-mul reset in_ready", 64'(in_ready), 64'd1);
    check("mid-mul reset out_valid", 64'(out_valid), 64'd0);
    check("mid-mul reset result", 64'(ALUResult), 64'd0);
    check("mid-mul reset flags", 64'(ALUFlags), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("aborted mul never completes", 64'(seen), 64'd0);
    run_single("add after reset", ADD, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
